conv_window_sequencer: RTL and testbench
========================================

Name: conv_window_sequencer

Overview:
- Registered read-address sequencer for the 1-D convolution datapath.
- Walks a circular input-feature (IF) buffer and a multi-filter buffer to produce MAC operand addresses with first/last markers.
- Stalls on data availability and accumulator backpressure, and releases consumed IF rows to the writer.
- Sits between the IF/filter scratch writers and the MAC/accumulator; a configurable-depth, multi-filter, multi-row successor to the combinational pointer checker.

Parameters:
- IF_DEPTH, 16, IF buffer words (power of 2)
- IF_ADDR_W, 4, log2(IF_DEPTH)
- FILT_DEPTH, 16, filter buffer words (power of 2)
- FILT_ADDR_W, 4, log2(FILT_DEPTH)
- SIZE_W, 5, width of if_size/filter_size config
- STRIDE_W, 3, stride config width
- NFILT_W, 3, filter-count config width
- ROWS_W, 8, row-count config width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  pulse; latch cfg_* and begin (ignored unless IDLE or DONE)
- cfg_stride  in  STRIDE_W  window step
- cfg_filter_size  in  SIZE_W  taps per filter
- cfg_if_size  in  SIZE_W  words per IF row
- cfg_num_filt  in  NFILT_W  filters stored contiguously from filter address 0
- cfg_rows  in  ROWS_W  IF rows to process
- if_wr_ptr  in  IF_ADDR_W+1  writer pointer incl. wrap bit
- filt_ready  in  1  level; filter buffer fully loaded
- acc_ready  in  1  level; accumulator accepts an issue
- if_rd_addr  out  IF_ADDR_W  IF operand address
- filt_rd_addr  out  FILT_ADDR_W  filter operand address
- mac_en  out  1  operand pair valid
- mac_first  out  1  first tap of window×filter
- mac_last  out  1  last tap of window×filter
- filt_idx  out  NFILT_W  filter index of current issue
- if_rd_ptr  out  IF_ADDR_W+1  release pointer incl. wrap bit (base of current row)
- if_full  out  1  (if_wr_ptr - if_rd_ptr) == IF_DEPTH
- row_done  out  1  one-cycle pulse after a row's final issue
- busy  out  1  state != IDLE/DONE
- done  out  1  level in DONE until next start
- cfg_err  out  1  one-cycle pulse on rejected start

Behaviour:
- Reset: state IDLE; all outputs 0; if_rd_ptr=0; counters k,s,f,row=0.
- Start checks: reject if filter_size==0, if_size==0, stride==0, filter_size>if_size, if_size>IF_DEPTH, num_filt==0, num_filt*filter_size>FILT_DEPTH, or rows==0. On reject: cfg_err=1 for one cycle, stay in current state.
- Iteration order: row outer, window s=0,stride,... while s+filter_size<=if_size, then filter f=0..num_filt-1, then tap k=0..filter_size-1 (innermost).
- States: IDLE -start ok-> RUN; RUN -last issue of last window of row-> ROW_END; ROW_END -row+1<rows-> RUN else DONE; DONE -start ok-> RUN.
- Issue condition in RUN: filt_ready & acc_ready & (s+k) < occupancy, where occupancy=(if_wr_ptr - if_rd_ptr) mod 2^(IF_ADDR_W+1). Otherwise stall: mac_en=0, counters hold.
- Issue registering: decided in cycle n, visible in cycle n+1.
  - if_rd_addr = (if_rd_ptr + s + k) mod IF_DEPTH
  - filt_rd_addr = f*filter_size + k
  - mac_first = (k==0); mac_last = (k==filter_size-1)
- mac_en falls the cycle after any stall condition appears; no issue is lost or duplicated.
- ROW_END (1 cycle): if_rd_ptr += if_size (wraps naturally on IF_ADDR_W+1 bits); row_done=1 on the following cycle; s,f,k cleared.
- Inputs are sampled combinationally in RUN; cfg_* is ignored after start.
- rst mid-operation returns to IDLE immediately with reset values; any in-flight accumulator state is the consumer's concern.

Decomposition:
- Shared package conv_pkg: state enum (IDLE/RUN/ROW_END/DONE) and config-check localparams.
- One sub-module, circ_occupancy: wrap-bit pointer subtract producing occupancy and full; reused by the writers.

Test Plan:
- IF_DEPTH=16; if_size=5, filter=3, stride=1, 1 filter, rows=1, if_wr_ptr=5 -> 9 issues; if_rd_addr 0,1,2,1,2,3,2,3,4; filt_rd_addr 0,1,2 ×3; mac_last on issues 3,6,9; row_done; if_rd_ptr=5; done.
- Same row, stride=2, num_filt=2 -> windows s=0,2; filt_rd_addr 0,1,2,3,4,5 per window; filt_idx 0,0,0,1,1,1; 12 issues total.
- if_wr_ptr=2 at start, raised to 5 at cycle 10 -> addrs 0,1 issued, mac_en=0 until ptr update, then sequence resumes at addr 2 with no gap or duplicate.
- IF_DEPTH=8, if_size=5, rows=2, ptr advanced to 10 -> second row reads 5,6,7 then 0,1...; final if_rd_ptr=10 (wrap bit set); if_full=1 when wr=13 and rd=5.
- acc_ready low for 3 cycles mid-window -> mac_en low 3 cycles; address sequence identical to the unstalled run.
- filter_size=6, if_size=5 -> cfg_err pulse, busy stays 0. Assert rst during RUN -> all outputs 0 next edge, and a new start runs a clean sequence.

Source files
------------

// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared state encoding and config legality check for the conv window sequencer
package conv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_ROW_END = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    // Wide enough for every window/tap/pointer sum so compares never truncate.
    localparam int CMP_W = 16;

    function automatic logic cfg_is_valid(
        input int stride,
        input int fsize,
        input int isize,
        input int nfilt,
        input int rows,
        input int if_depth,
        input int filt_depth
    );
        return !(fsize == 0 || isize == 0 || stride == 0 || fsize > isize ||
                 isize > if_depth || nfilt == 0 || nfilt * fsize > filt_depth || rows == 0);
    endfunction

endpackage

// File: rtl/circ_occupancy.sv
// rtl/circ_occupancy.sv - wrap-bit pointer subtract giving circular buffer occupancy and full flag
module circ_occupancy #(
    parameter int ADDR_W = 4
) (
    input  logic [ADDR_W:0] wr_ptr,
    input  logic [ADDR_W:0] rd_ptr,
    output logic [ADDR_W:0] occupancy,
    output logic            full
);

    assign occupancy = wr_ptr - rd_ptr;
    assign full      = (occupancy == {1'b1, {ADDR_W{1'b0}}});

endmodule

// File: rtl/conv_window_sequencer.sv
// rtl/conv_window_sequencer.sv - registered IF/filter read-address sequencer for the 1-D conv MAC
module conv_window_sequencer
    import conv_pkg::*;
#(
    parameter int IF_DEPTH    = 16,
    parameter int IF_ADDR_W   = 4,
    parameter int FILT_DEPTH  = 16,
    parameter int FILT_ADDR_W = 4,
    parameter int SIZE_W      = 5,
    parameter int STRIDE_W    = 3,
    parameter int NFILT_W     = 3,
    parameter int ROWS_W      = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [STRIDE_W-1:0]    cfg_stride,
    input  logic [SIZE_W-1:0]      cfg_filter_size,
    input  logic [SIZE_W-1:0]      cfg_if_size,
    input  logic [NFILT_W-1:0]     cfg_num_filt,
    input  logic [ROWS_W-1:0]      cfg_rows,
    input  logic [IF_ADDR_W:0]     if_wr_ptr,
    input  logic                   filt_ready,
    input  logic                   acc_ready,
    output logic [IF_ADDR_W-1:0]   if_rd_addr,
    output logic [FILT_ADDR_W-1:0] filt_rd_addr,
    output logic                   mac_en,
    output logic                   mac_first,
    output logic                   mac_last,
    output logic [NFILT_W-1:0]     filt_idx,
    output logic [IF_ADDR_W:0]     if_rd_ptr,
    output logic                   if_full,
    output logic                   row_done,
    output logic                   busy,
    output logic                   done,
    output logic                   cfg_err
);

    state_t state, state_d;

    logic [STRIDE_W-1:0] stride_q;
    logic [SIZE_W-1:0]   fsize_q, isize_q;
    logic [NFILT_W-1:0]  nfilt_q;
    logic [ROWS_W-1:0]   rows_q;

    logic [SIZE_W-1:0]   s_q, s_d, k_q, k_d;
    logic [NFILT_W-1:0]  f_q, f_d;
    logic [ROWS_W-1:0]   row_q, row_d;
    logic [IF_ADDR_W:0]  rd_ptr_d;

    logic [IF_ADDR_W-1:0]   if_addr_d;
    logic [FILT_ADDR_W-1:0] filt_addr_d;
    logic [NFILT_W-1:0]     filt_idx_d;
    logic mac_en_d, first_d, last_d, row_done_d, cfg_err_d;

    logic [IF_ADDR_W:0] occupancy;
    logic [CMP_W-1:0]   tap_off;
    logic start_ok, accept, issue, last_tap, last_filt, last_win;

    circ_occupancy #(.ADDR_W(IF_ADDR_W)) u_occ (
        .wr_ptr    (if_wr_ptr),
        .rd_ptr    (if_rd_ptr),
        .occupancy (occupancy),
        .full      (if_full)
    );

    assign start_ok = cfg_is_valid(int'(cfg_stride), int'(cfg_filter_size), int'(cfg_if_size),
                                   int'(cfg_num_filt), int'(cfg_rows), IF_DEPTH, FILT_DEPTH);
    assign accept   = start && start_ok && (state == ST_IDLE || state == ST_DONE);

    assign tap_off   = CMP_W'(s_q) + CMP_W'(k_q);
    assign issue     = filt_ready && acc_ready && (tap_off < CMP_W'(occupancy));
    assign last_tap  = (k_q == fsize_q - SIZE_W'(1));
    assign last_filt = (f_q == nfilt_q - NFILT_W'(1));
    // The next window would overrun the row, so this is the row's final window.
    assign last_win  = (CMP_W'(s_q) + CMP_W'(stride_q) + CMP_W'(fsize_q)) > CMP_W'(isize_q);

    assign busy = (state == ST_RUN) || (state == ST_ROW_END);
    assign done = (state == ST_DONE);

    always_comb begin
        state_d     = state;
        s_d         = s_q;
        k_d         = k_q;
        f_d         = f_q;
        row_d       = row_q;
        rd_ptr_d    = if_rd_ptr;
        if_addr_d   = if_rd_addr;
        filt_addr_d = filt_rd_addr;
        filt_idx_d  = filt_idx;
        mac_en_d    = 1'b0;
        first_d     = 1'b0;
        last_d      = 1'b0;
        row_done_d  = 1'b0;
        cfg_err_d   = 1'b0;
        unique case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    if (start_ok) begin
                        state_d = ST_RUN;
                        s_d     = '0;
                        k_d     = '0;
                        f_d     = '0;
                        row_d   = '0;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (issue) begin
                    mac_en_d    = 1'b1;
                    first_d     = (k_q == '0);
                    last_d      = last_tap;
                    filt_idx_d  = f_q;
                    if_addr_d   = IF_ADDR_W'(CMP_W'(if_rd_ptr) + tap_off);
                    filt_addr_d = FILT_ADDR_W'(CMP_W'(f_q) * CMP_W'(fsize_q) + CMP_W'(k_q));
                    if (!last_tap) begin
                        k_d = k_q + SIZE_W'(1);
                    end else begin
                        k_d = '0;
                        if (!last_filt) begin
                            f_d = f_q + NFILT_W'(1);
                        end else begin
                            f_d = '0;
                            if (last_win) begin
                                state_d = ST_ROW_END;
                            end else begin
                                s_d = SIZE_W'(CMP_W'(s_q) + CMP_W'(stride_q));
                            end
                        end
                    end
                end
            end
            ST_ROW_END: begin
                // Release the finished row back to the writer.
                rd_ptr_d   = if_rd_ptr + (IF_ADDR_W+1)'(isize_q);
                row_done_d = 1'b1;
                s_d        = '0;
                k_d        = '0;
                f_d        = '0;
                if ((CMP_W'(row_q) + CMP_W'(1)) < CMP_W'(rows_q)) begin
                    row_d   = row_q + ROWS_W'(1);
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            s_q          <= '0;
            k_q          <= '0;
            f_q          <= '0;
            row_q        <= '0;
            if_rd_ptr    <= '0;
            if_rd_addr   <= '0;
            filt_rd_addr <= '0;
            filt_idx     <= '0;
            mac_en       <= 1'b0;
            mac_first    <= 1'b0;
            mac_last     <= 1'b0;
            row_done     <= 1'b0;
            cfg_err      <= 1'b0;
        end else begin
            state        <= state_d;
            s_q          <= s_d;
            k_q          <= k_d;
            f_q          <= f_d;
            row_q        <= row_d;
            if_rd_ptr    <= rd_ptr_d;
            if_rd_addr   <= if_addr_d;
            filt_rd_addr <= filt_addr_d;
            filt_idx     <= filt_idx_d;
            mac_en       <= mac_en_d;
            mac_first    <= first_d;
            mac_last     <= last_d;
            row_done     <= row_done_d;
            cfg_err      <= cfg_err_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stride_q <= '0;
            fsize_q  <= '0;
            isize_q  <= '0;
            nfilt_q  <= '0;
            rows_q   <= '0;
        end else if (accept) begin
            stride_q <= cfg_stride;
            fsize_q  <= cfg_filter_size;
            isize_q  <= cfg_if_size;
            nfilt_q  <= cfg_num_filt;
            rows_q   <= cfg_rows;
        end
    end

endmodule

// File: tb/tb_conv_window_sequencer.sv
// tb/tb_conv_window_sequencer.sv - self-checking bench for conv_window_sequencer
module tb_conv_window_sequencer;

    localparam int IF_DEPTH = 16;
    localparam int PTR_MOD  = 2 * IF_DEPTH;

    logic       clk = 1'b0;
    logic       rst, start, filt_ready, acc_ready;
    logic [2:0] cfg_stride;
    logic [4:0] cfg_filter_size, cfg_if_size;
    logic [2:0] cfg_num_filt;
    logic [7:0] cfg_rows;
    logic [4:0] if_wr_ptr;
    logic [3:0] if_rd_addr, filt_rd_addr;
    logic       mac_en, mac_first, mac_last;
    logic [2:0] filt_idx;
    logic [4:0] if_rd_ptr;
    logic       if_full, row_done, busy, done, cfg_err;

    int checks = 0;
    int errors = 0;
    int model_rd = 0;

    typedef struct {
        int off;
        int row;
        int faddr;
        int first;
        int last;
        int fidx;
        int row_last;
    } issue_t;

    issue_t exp_q[$];

    conv_window_sequencer dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .cfg_stride      (cfg_stride),
        .cfg_filter_size (cfg_filter_size),
        .cfg_if_size     (cfg_if_size),
        .cfg_num_filt    (cfg_num_filt),
        .cfg_rows        (cfg_rows),
        .if_wr_ptr       (if_wr_ptr),
        .filt_ready      (filt_ready),
        .acc_ready       (acc_ready),
        .if_rd_addr      (if_rd_addr),
        .filt_rd_addr    (filt_rd_addr),
        .mac_en          (mac_en),
        .mac_first       (mac_first),
        .mac_last        (mac_last),
        .filt_idx        (filt_idx),
        .if_rd_ptr       (if_rd_ptr),
        .if_full         (if_full),
        .row_done        (row_done),
        .busy            (busy),
        .done            (done),
        .cfg_err         (cfg_err)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] to_ptr(input int v);
        return 5'(v % PTR_MOD);
    endfunction

    function automatic logic [23:0] all_outputs();
        return {mac_en, mac_first, mac_last, row_done, busy, done, cfg_err, if_full,
                if_rd_addr, filt_rd_addr, filt_idx, if_rd_ptr};
    endfunction

    // Expected operand stream: rows, then windows, then filters, then taps.
    function automatic void build_model(input int stride, input int fs, input int ifs,
                                        input int nf, input int rows);
        issue_t e;
        exp_q.delete();
        for (int r = 0; r < rows; r++) begin
            for (int s = 0; s + fs <= ifs; s += stride) begin
                for (int f = 0; f < nf; f++) begin
                    for (int k = 0; k < fs; k++) begin
                        e.off = s + k;
                        e.row = r;
                        e.faddr = f * fs + k;
                        e.first = (k == 0);
                        e.last = (k == fs - 1);
                        e.fidx = f;
                        e.row_last = 0;
                        exp_q.push_back(e);
                    end
                end
            end
            exp_q[exp_q.size()-1].row_last = 1;
        end
    endfunction

    task automatic drive_cfg(input int stride, input int fs, input int ifs, input int nf, input int rows);
        cfg_stride      = 3'(stride);
        cfg_filter_size = 5'(fs);
        cfg_if_size     = 5'(ifs);
        cfg_num_filt    = 3'(nf);
        cfg_rows        = 8'(rows);
    endtask

    task automatic run_job(input int stride, input int fs, input int ifs, input int nf, input int rows,
                           input bit rand_mode, input int hold, input int acc_low_at,
                           output int cycles, output int issued_at_hold);
        issue_t e;
        int base0, row_cur, wr, prev_wr, it, pulses, exp_addr, avail, target, issued;
        bit prev_rdy, finished;
        logic [12:0] got, expv;
        build_model(stride, fs, ifs, nf, rows);
        base0 = model_rd;
        row_cur = 0;
        pulses = 0;
        issued = 0;
        issued_at_hold = 0;
        finished = 0;
        it = 0;
        if (hold > 0) wr = base0 + 2;
        else if (rand_mode) wr = base0;
        else wr = base0 + ifs;
        @(negedge clk);
        drive_cfg(stride, fs, ifs, nf, rows);
        start = 1'b1;
        acc_ready = 1'b1;
        filt_ready = 1'b1;
        if_wr_ptr = to_ptr(wr);
        prev_wr = wr;
        prev_rdy = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!finished && it < 4000) begin
            @(negedge clk);
            it++;
            if (mac_en) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_issue: got if_rd_addr %0d, required no issue", if_rd_addr);
                end else begin
                    e = exp_q.pop_front();
                    issued++;
                    exp_addr = (base0 + e.row * ifs + e.off) % IF_DEPTH;
                    got  = {if_rd_addr, filt_rd_addr, mac_first, mac_last, filt_idx};
                    expv = {4'(exp_addr), 4'(e.faddr), 1'(e.first), 1'(e.last), 3'(e.fidx)};
                    if (got !== expv) begin
                        errors++;
                        $display("FAIL issue_fields row %0d off %0d: got %h required %h", e.row, e.off, got, expv);
                    end
                    avail = ((prev_wr - (base0 + e.row * ifs)) % PTR_MOD + PTR_MOD) % PTR_MOD;
                    checks++;
                    if (!(prev_rdy && e.off < avail)) begin
                        errors++;
                        $display("FAIL issue_unready off %0d: got issue with ready %0d avail %0d, required stall",
                                 e.off, prev_rdy, avail);
                    end
                    if (e.row_last != 0) begin
                        row_cur++;
                        wr = rand_mode ? base0 + row_cur * ifs : base0 + (row_cur + 1) * ifs;
                    end
                end
            end
            if (row_done) pulses++;
            finished = done && (exp_q.size() == 0);
            if (hold > 0 && it == hold) begin
                issued_at_hold = issued;
                wr = base0 + ifs;
            end
            if (acc_low_at > 0 && it == acc_low_at) acc_ready = 1'b0;
            if (acc_low_at > 0 && it == acc_low_at + 3) acc_ready = 1'b1;
            if (rand_mode) begin
                acc_ready  = ($urandom_range(0, 3) != 0);
                filt_ready = ($urandom_range(0, 3) != 0);
                target = base0 + (row_cur + 1) * ifs;
                if (wr < target && $urandom_range(0, 1) == 1) wr++;
            end
            if_wr_ptr = to_ptr(wr);
            prev_wr = wr;
            prev_rdy = acc_ready && filt_ready;
        end
        cycles = it;
        checks++;
        if (!finished) begin
            errors++;
            $display("FAIL job_timeout: got %0d issues left after %0d cycles, required 0", exp_q.size(), it);
        end
        checks++;
        if (pulses != rows) begin
            errors++;
            $display("FAIL row_done_count: got %0d required %0d", pulses, rows);
        end
        checks++;
        if (if_rd_ptr !== to_ptr(base0 + rows * ifs)) begin
            errors++;
            $display("FAIL final_rd_ptr: got %0d required %0d", if_rd_ptr, to_ptr(base0 + rows * ifs));
        end
        checks++;
        if ({busy, done} !== 2'b01) begin
            errors++;
            $display("FAIL end_state busy/done: got %b required 01", {busy, done});
        end
        model_rd = (base0 + rows * ifs) % PTR_MOD;
        acc_ready = 1'b1;
        filt_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        drive_cfg(0, 0, 0, 0, 0);
        if_wr_ptr = '0;
        acc_ready = 1'b0;
        filt_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (all_outputs() !== 24'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h required 0", all_outputs());
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, mac_en} !== 3'b000) begin
            errors++;
            $display("FAIL idle_after_reset: got %b required 000", {busy, done, mac_en});
        end
        model_rd = 0;
    endtask

    task automatic test_basic();
        int cyc, h;
        run_job(1, 3, 5, 1, 1, 1'b0, 0, -1, cyc, h);
        checks++;
        if (cyc != 10) begin
            errors++;
            $display("FAIL basic_cycles: got %0d required 10", cyc);
        end
    endtask

    task automatic test_multi_filter();
        int cyc, h;
        run_job(2, 3, 5, 2, 1, 1'b0, 0, -1, cyc, h);
        checks++;
        if (cyc != 13) begin
            errors++;
            $display("FAIL multi_filter_cycles: got %0d required 13", cyc);
        end
    endtask

    task automatic test_data_stall();
        int cyc, h;
        run_job(1, 3, 5, 1, 1, 1'b0, 10, -1, cyc, h);
        checks++;
        if (h != 2) begin
            errors++;
            $display("FAIL data_stall_issued: got %0d required 2", h);
        end
        checks++;
        if (cyc != 18) begin
            errors++;
            $display("FAIL data_stall_cycles: got %0d required 18", cyc);
        end
    endtask

    task automatic test_acc_stall();
        int cyc, h;
        run_job(1, 3, 5, 1, 1, 1'b0, 0, 4, cyc, h);
        checks++;
        if (cyc != 13) begin
            errors++;
            $display("FAIL acc_stall_cycles: got %0d required 13", cyc);
        end
    endtask

    task automatic test_wrap();
        int cyc, h;
        run_job(1, 2, 5, 2, 4, 1'b1, 0, -1, cyc, h);
        @(negedge clk);
        if_wr_ptr = to_ptr(model_rd + IF_DEPTH);
        #1;
        checks++;
        if (if_full !== 1'b1) begin
            errors++;
            $display("FAIL if_full_set: got %b required 1", if_full);
        end
        if_wr_ptr = to_ptr(model_rd + IF_DEPTH - 1);
        #1;
        checks++;
        if (if_full !== 1'b0) begin
            errors++;
            $display("FAIL if_full_clear: got %b required 0", if_full);
        end
    endtask

    task automatic test_cfg_err();
        int bad [8][5] = '{'{1, 6, 5, 1, 1}, '{0, 3, 5, 1, 1}, '{1, 3, 0, 1, 1}, '{1, 0, 5, 1, 1},
                           '{1, 3, 17, 1, 1}, '{1, 3, 5, 0, 1}, '{1, 3, 16, 6, 1}, '{1, 3, 5, 1, 0}};
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive_cfg(bad[i][0], bad[i][1], bad[i][2], bad[i][3], bad[i][4]);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            checks++;
            if ({cfg_err, busy, done} !== 3'b101) begin
                errors++;
                $display("FAIL cfg_err_pulse case %0d: got cfg_err/busy/done %b required 101", i, {cfg_err, busy, done});
            end
            @(negedge clk);
            checks++;
            if (cfg_err !== 1'b0) begin
                errors++;
                $display("FAIL cfg_err_width case %0d: got %b required 0", i, cfg_err);
            end
        end
    endtask

    task automatic test_rst_mid();
        int cyc, h;
        @(negedge clk);
        drive_cfg(1, 3, 5, 1, 1);
        if_wr_ptr = to_ptr(model_rd + 5);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        if_wr_ptr = '0;
        rst = 1'b1;
        #1;
        checks++;
        if (all_outputs() !== 24'h0) begin
            errors++;
            $display("FAIL rst_mid_async: got %h required 0", all_outputs());
        end
        @(posedge clk);
        #1;
        checks++;
        if (all_outputs() !== 24'h0) begin
            errors++;
            $display("FAIL rst_mid_edge: got %h required 0", all_outputs());
        end
        @(negedge clk);
        rst = 1'b0;
        model_rd = 0;
        run_job(1, 3, 5, 1, 1, 1'b0, 0, -1, cyc, h);
        checks++;
        if (cyc != 10) begin
            errors++;
            $display("FAIL rst_clean_cycles: got %0d required 10", cyc);
        end
    endtask

    task automatic test_random();
        int cyc, h, ifs, fs, nf, nf_max, stride, rows;
        for (int j = 0; j < 6; j++) begin
            ifs = $urandom_range(1, IF_DEPTH);
            fs = $urandom_range(1, ifs);
            nf_max = (16 / fs > 7) ? 7 : 16 / fs;
            nf = $urandom_range(1, nf_max);
            stride = $urandom_range(1, 7);
            rows = $urandom_range(1, 3);
            run_job(stride, fs, ifs, nf, rows, 1'b1, 0, -1, cyc, h);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_multi_filter();
        test_data_stall();
        test_acc_stall();
        test_wrap();
        test_cfg_err();
        test_rst_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
